// File: rtl/indexed_slot_buffer.sv
// indexed_slot_buffer: random-access elastic buffer; writes take a free slot, reads address slots by index.
// Optional macro RAND_ALLOC_EN: LFSR-seeded circular free-slot search instead of lowest-free allocation.
module indexed_slot_buffer #(
  parameter int DEPTH = 32,
  parameter int WIDTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [WIDTH-1:0] wr_data,
  output logic [AW-1:0]    wr_idx,
  input  logic             rd_req,
  input  logic             rd_keep,
  input  logic [AW-1:0]    rd_idx,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  output logic             rd_err,
  output logic [AW:0]      count,
  output logic             empty,
  output logic             full
);
  localparam int SW = 1 << AW;
  logic [DEPTH-1:0] valid;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [SW-1:0]    vext;
  logic             wr_acc, rd_hit, rd_ok, cons;
  // Zero-padded bitmap makes out-of-range indices read as empty slots.
  assign vext     = SW'(valid);
  assign wr_ready = ~&valid;
  assign wr_acc   = wr_valid && wr_ready && !flush;
  assign rd_hit   = rd_req && vext[rd_idx];
  assign rd_ok    = rd_hit && !flush;
  assign cons     = rd_ok && !rd_keep;
  assign empty    = count == '0;
  assign full     = count == (AW+1)'(DEPTH);
`ifdef RAND_ALLOC_EN
  logic [15:0]        lfsr;
  logic [2*DEPTH-1:0] rot;
  int                 s, o;
  always_ff @(posedge clk or posedge rst)
    if (rst) lfsr <= 16'hACE1;
    else lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  // Rotating the doubled free map turns the circular search into a lowest-set-bit search.
  always_comb begin
    s = int'(lfsr) % DEPTH;
    rot = {~valid, ~valid} >> s;
    o = 0;
    for (int i = DEPTH - 1; i >= 0; i--) if (rot[i]) o = i;
    wr_idx = wr_ready ? AW'((s + o) % DEPTH) : '0;
  end
`else
  always_comb begin
    wr_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) if (!valid[i]) wr_idx = AW'(i);
  end
`endif
  always_ff @(posedge clk)
    if (wr_acc) mem[wr_idx] <= wr_data;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      valid    <= '0;
      count    <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
      rd_err   <= 1'b0;
    end else begin
      rd_valid <= rd_ok;
      rd_err   <= rd_req && !rd_hit && !flush;
      if (rd_ok) rd_data <= mem[rd_idx];
      if (flush) begin
        valid <= '0;
        count <= '0;
      end else begin
        if (wr_acc) valid[wr_idx] <= 1'b1;
        if (cons) valid[rd_idx] <= 1'b0;
        count <= count + {{AW{1'b0}}, wr_acc} - {{AW{1'b0}}, cons};
      end
    end
endmodule

// File: tb/tb_indexed_slot_buffer.sv
// tb_indexed_slot_buffer: directed and randomized checks of indexed_slot_buffer against a slot-array model.
module tb_indexed_slot_buffer;
  localparam int D = 32;
  logic clk = 0, rst = 1, flush = 0, wr_valid = 0, rd_req = 0, rd_keep = 0;
  logic [7:0] wr_data = 0;
  logic [4:0] rd_idx = 0;
  logic wr_ready, rd_valid, rd_err, empty, full;
  logic [4:0] wr_idx;
  logic [7:0] rd_data;
  logic [5:0] count;
  logic b_flush = 0, b_wr_valid = 0, b_rd_req = 0, b_rd_keep = 0;
  logic [7:0] b_wr_data = 0;
  logic [4:0] b_rd_idx = 0;
  logic b_wr_ready, b_rd_valid, b_rd_err, b_empty, b_full;
  logic [4:0] b_wr_idx;
  logic [7:0] b_rd_data;
  logic [5:0] b_count;
  int total = 0, bad = 0;

  indexed_slot_buffer #(.DEPTH(D), .WIDTH(8)) dut (
    .clk(clk), .rst(rst), .flush(flush), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_data(wr_data), .wr_idx(wr_idx), .rd_req(rd_req), .rd_keep(rd_keep), .rd_idx(rd_idx),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_err(rd_err), .count(count), .empty(empty), .full(full));

  indexed_slot_buffer #(.DEPTH(24), .WIDTH(8)) u24 (
    .clk(clk), .rst(rst), .flush(b_flush), .wr_valid(b_wr_valid), .wr_ready(b_wr_ready),
    .wr_data(b_wr_data), .wr_idx(b_wr_idx), .rd_req(b_rd_req), .rd_keep(b_rd_keep), .rd_idx(b_rd_idx),
    .rd_data(b_rd_data), .rd_valid(b_rd_valid), .rd_err(b_rd_err), .count(b_count), .empty(b_empty), .full(b_full));

  always #5 clk = ~clk;

  bit         mv [D];
  logic [7:0] mm [D];
  logic [7:0] m_rd = 0;
  bit         m_rv = 0, m_re = 0;
  logic [15:0] m_lfsr = 16'hACE1;

  function automatic int m_count();
    int n = 0;
    for (int i = 0; i < D; i++) n += int'(mv[i]);
    return n;
  endfunction

  function automatic int m_alloc();
    if (m_count() == D) return 0;
`ifdef RAND_ALLOC_EN
    for (int k = 0; k < D; k++) if (!mv[(int'(m_lfsr) % D + k) % D]) return (int'(m_lfsr) % D + k) % D;
`else
    for (int i = 0; i < D; i++) if (!mv[i]) return i;
`endif
    return 0;
  endfunction

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", n, act, exp, $time);
    end
  endtask

  // Reference model: slot array updated from pre-edge state each rising edge.
  initial begin
    int w;
    bit wa;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        for (int i = 0; i < D; i++) mv[i] = 0;
        m_rd = 0; m_rv = 0; m_re = 0; m_lfsr = 16'hACE1;
      end else begin
        w = m_alloc();
        wa = wr_valid && m_count() < D;
        m_rv = 0; m_re = 0;
        if (flush) for (int i = 0; i < D; i++) mv[i] = 0;
        else begin
          if (rd_req) begin
            if (int'(rd_idx) < D && mv[rd_idx]) begin
              m_rd = mm[rd_idx]; m_rv = 1;
              if (!rd_keep) mv[rd_idx] = 0;
            end else m_re = 1;
          end
          if (wa) begin mv[w] = 1; mm[w] = wr_data; end
        end
        m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
      end
    end
  end

  initial begin
    @(negedge rst);
    forever begin
      @(negedge clk);
      chk("wr_ready", wr_ready, m_count() < D);
      if (m_count() < D) chk("wr_idx", wr_idx, m_alloc());
      chk("count", count, m_count());
      chk("empty", empty, m_count() == 0);
      chk("full", full, m_count() == D);
      chk("rd_valid", rd_valid, m_rv);
      chk("rd_err", rd_err, m_re);
      chk("rd_data", rd_data, m_rd);
    end
  end

  task automatic cyc(input bit wv, input logic [7:0] wd, input bit rq, input bit kp, input logic [4:0] ri, input bit fl);
    wr_valid = wv; wr_data = wd; rd_req = rq; rd_keep = kp; rd_idx = ri; flush = fl;
    @(posedge clk); #1;
    wr_valid = 0; rd_req = 0; flush = 0;
  endtask

  task automatic cyc24(input bit wv, input logic [7:0] wd, input bit rq, input bit kp, input logic [4:0] ri);
    b_wr_valid = wv; b_wr_data = wd; b_rd_req = rq; b_rd_keep = kp; b_rd_idx = ri;
    @(posedge clk); #1;
    b_wr_valid = 0; b_rd_req = 0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 0;
`ifndef RAND_ALLOC_EN
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_data", rd_data, 0);
    for (int i = 0; i < 3; i++) begin
      chk("seq_wr_idx", wr_idx, i);
      cyc(1, 8'hA1 + 8'(i), 0, 0, 0, 0);
    end
    chk("seq_count", count, 3);
    chk("seq_empty", empty, 0);
    cyc(0, 0, 1, 0, 1, 0);
    chk("cons_valid", rd_valid, 1);
    chk("cons_data", rd_data, 8'hA2);
    chk("reuse_idx", wr_idx, 1);
    cyc(1, 8'hB4, 0, 0, 0, 0);
    chk("pulse_end", rd_valid, 0);
    chk("reuse_count", count, 3);
    for (int i = 0; i < 2; i++) begin
      cyc(0, 0, 1, 1, 0, 0);
      chk("peek_data", rd_data, 8'hA1);
    end
    cyc(0, 0, 1, 0, 0, 0);
    chk("cons0_data", rd_data, 8'hA1);
    chk("cons0_count", count, 2);
    cyc(0, 0, 1, 0, 0, 0);
    chk("reread_err", rd_err, 1);
    chk("reread_valid", rd_valid, 0);
    chk("reread_hold", rd_data, 8'hA1);
    cyc(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < D; i++) cyc(1, 8'h10 + 8'(i), 0, 0, 0, 0);
    chk("fill_full", full, 1);
    chk("fill_count", count, 32);
    chk("fill_ready", wr_ready, 0);
    cyc(1, 8'hEE, 1, 0, 5, 0);
    chk("fc_data", rd_data, 8'h15);
    chk("fc_ready", wr_ready, 1);
    chk("fc_idx", wr_idx, 5);
    chk("fc_full", full, 0);
    chk("fc_count", count, 31);
    cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 0, 1, 0, 7, 0);
    chk("empty_err", rd_err, 1);
    chk("empty_valid", rd_valid, 0);
    chk("empty_hold", rd_data, 8'h15);
    cyc(0, 0, 0, 0, 0, 0);
    chk("err_pulse", rd_err, 0);
    cyc24(0, 0, 1, 0, 30);
    chk("d24_oor_err", b_rd_err, 1);
    chk("d24_oor_valid", b_rd_valid, 0);
    chk("d24_oor_data", b_rd_data, 0);
    for (int i = 0; i < 24; i++) begin
      chk("d24_idx", b_wr_idx, i);
      cyc24(1, 8'h40 + 8'(i), 0, 0, 0);
    end
    chk("d24_full", b_full, 1);
    chk("d24_count", b_count, 24);
    chk("d24_ready", b_wr_ready, 0);
    cyc24(0, 0, 1, 1, 23);
    chk("d24_peek", b_rd_data, 8'h57);
    cyc24(0, 0, 1, 0, 30);
    chk("d24_oor2_err", b_rd_err, 1);
    chk("d24_oor2_hold", b_rd_data, 8'h57);
    for (int i = 0; i < 4; i++) cyc(1, 8'h60 + 8'(i), 0, 0, 0, 0);
    cyc(1, 8'h77, 1, 0, 0, 1);
    chk("fl_count", count, 0);
    chk("fl_empty", empty, 1);
    chk("fl_valid", rd_valid, 0);
    chk("fl_err", rd_err, 0);
    cyc(1, 8'h81, 0, 0, 0, 0);
    cyc(1, 8'h82, 0, 0, 0, 0);
    wr_valid = 1; rd_req = 1; rd_idx = 0;
    #2 rst = 1;
    @(posedge clk); #1;
    chk("mr_valid", rd_valid, 0);
    chk("mr_err", rd_err, 0);
    chk("mr_count", count, 0);
    chk("mr_empty", empty, 1);
    wr_valid = 0; rd_req = 0; rst = 0;
    chk("mr_idx", wr_idx, 0);
`endif
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 499) == 0) begin
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
      end else
        cyc($urandom_range(0, 9) < 6, 8'($urandom), $urandom_range(0, 1) == 1,
            $urandom_range(0, 9) < 3, 5'($urandom_range(0, 31)), $urandom_range(0, 63) == 0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
